// File: rtl/hdmi_fb_writer_if.sv
// Framebuffer writer bus: packet request, 64-bit data stream, buffer select
// and the dedicated MCB write port, bundled for the writer and its neighbours.
interface hdmi_fb_writer_if #(
  parameter int LEN_W = 8
);
  logic             pkt_start_in;
  logic             pkt_ready_out;
  logic [18:0]      pkt_addr_in;
  logic [LEN_W-1:0] pkt_len_in;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic             fb_swap_in;
  logic             fb_num_out;
  logic             done_out;
  logic             err_out;
  logic             mcb_cmd_en_out;
  logic [2:0]       mcb_cmd_instr_out;
  logic [5:0]       mcb_cmd_bl_out;
  logic [29:0]      mcb_cmd_byte_addr_out;
  logic             mcb_cmd_full_in;
  logic             mcb_wr_en_out;
  logic [7:0]       mcb_wr_mask_out;
  logic [63:0]      mcb_wr_data_out;
  logic             mcb_wr_full_in;
  logic             mcb_wr_error_in;
  logic             mcb_wr_underrun_in;

  modport slave (
    input  pkt_start_in, pkt_addr_in, pkt_len_in, in_valid, in_data, fb_swap_in,
           mcb_cmd_full_in, mcb_wr_full_in, mcb_wr_error_in, mcb_wr_underrun_in,
    output pkt_ready_out, in_ready, fb_num_out, done_out, err_out,
           mcb_cmd_en_out, mcb_cmd_instr_out, mcb_cmd_bl_out, mcb_cmd_byte_addr_out,
           mcb_wr_en_out, mcb_wr_mask_out, mcb_wr_data_out
  );

  modport master (
    output pkt_start_in, pkt_addr_in, pkt_len_in, in_valid, in_data, fb_swap_in,
           mcb_cmd_full_in, mcb_wr_full_in, mcb_wr_error_in, mcb_wr_underrun_in,
    input  pkt_ready_out, in_ready, fb_num_out, done_out, err_out,
           mcb_cmd_en_out, mcb_cmd_instr_out, mcb_cmd_bl_out, mcb_cmd_byte_addr_out,
           mcb_wr_en_out, mcb_wr_mask_out, mcb_wr_data_out
  );
endinterface

// File: rtl/hdmi_fb_writer.sv
// Framebuffer fill stage: turns write packets into BEATS-word MCB write
// bursts (data first, then the command) and owns the double-buffer select.
module hdmi_fb_writer #(
  parameter int LEN_W = 8,
  parameter int BEATS = 8
) (
  input logic             clk,
  input logic             rst,
  hdmi_fb_writer_if.slave bus
);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, DATA, CMD} state_t;

  state_t           state;
  logic [18:0]      burst_addr;
  logic [CNT_W-1:0] word_cnt;
  logic [LEN_W-1:0] bursts_left;
  logic             swap_pend;
  logic             fb_num;
  logic             done;
  logic             err;
  logic             accept;
  logic             issue;

  // Handshakes are combinational on the registered state and the FIFO flags.
  always_comb begin
    accept = (state == DATA) && bus.in_valid && !bus.mcb_wr_full_in;
    issue  = (state == CMD) && !bus.mcb_cmd_full_in;
  end

  assign bus.pkt_ready_out         = (state == IDLE);
  assign bus.in_ready              = (state == DATA) && !bus.mcb_wr_full_in;
  assign bus.mcb_wr_en_out         = accept;
  assign bus.mcb_wr_data_out       = bus.in_data;
  assign bus.mcb_wr_mask_out       = '0;
  assign bus.mcb_cmd_en_out        = issue;
  assign bus.mcb_cmd_instr_out     = 3'b000;
  assign bus.mcb_cmd_bl_out        = 6'(BEATS - 1);
  assign bus.mcb_cmd_byte_addr_out = {5'b0, burst_addr, 6'b0};
  assign bus.fb_num_out            = fb_num;
  assign bus.done_out              = done;
  assign bus.err_out               = err;

  // Packet sequencing, burst addressing, buffer swap and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      burst_addr  <= '0;
      word_cnt    <= '0;
      bursts_left <= '0;
      swap_pend   <= 1'b0;
      fb_num      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.mcb_wr_error_in || bus.mcb_wr_underrun_in) err <= 1'b1;

      // A swap request seen while idle acts at once; otherwise it waits for
      // the packet to finish so a frame is never split across buffers.
      if (state == IDLE && (swap_pend || bus.fb_swap_in)) begin
        fb_num    <= ~fb_num;
        swap_pend <= 1'b0;
      end else if (bus.fb_swap_in) begin
        swap_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.pkt_start_in) begin
            burst_addr  <= bus.pkt_addr_in;
            bursts_left <= bus.pkt_len_in;
            word_cnt    <= '0;
            if (bus.pkt_len_in == '0) done  <= 1'b1;
            else                      state <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            if (word_cnt == CNT_W'(BEATS - 1)) begin
              word_cnt <= '0;
              state    <= CMD;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        CMD: begin
          if (issue) begin
            burst_addr[17:0] <= burst_addr[17:0] + 18'd1;
            bursts_left      <= bursts_left - LEN_W'(1);
            if (bursts_left == LEN_W'(1)) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= DATA;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hdmi_fb_writer.sv
// Randomized self-checking bench for hdmi_fb_writer with a packet-level model.
module tb_hdmi_fb_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic fb_exp = 1'b0;

  always #5 clk = ~clk;

  hdmi_fb_writer_if #(.LEN_W(8)) bus();

  hdmi_fb_writer #(.LEN_W(8), .BEATS(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pkt_start_in       = 1'b0;
    bus.pkt_addr_in        = '0;
    bus.pkt_len_in         = '0;
    bus.in_valid           = 1'b0;
    bus.in_data            = '0;
    bus.fb_swap_in         = 1'b0;
    bus.mcb_cmd_full_in    = 1'b0;
    bus.mcb_wr_full_in     = 1'b0;
    bus.mcb_wr_error_in    = 1'b0;
    bus.mcb_wr_underrun_in = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [6:0] flags;
    flags = {bus.pkt_ready_out, bus.in_ready, bus.mcb_wr_en_out, bus.mcb_cmd_en_out,
             bus.done_out, bus.err_out, bus.fb_num_out};
    checks++;
    if (flags !== 7'b1000000) begin
      errors++;
      $display("FAIL %s_flags got %b want 1000000", tag, flags);
    end
    checks++;
    if (bus.mcb_cmd_byte_addr_out !== 30'h0) begin
      errors++;
      $display("FAIL %s_byte_addr got %h want 0", tag, bus.mcb_cmd_byte_addr_out);
    end
  endtask

  // Runs one packet with randomized flow control plus optional forced-full
  // windows; checks every MCB transaction against the packet-level model.
  task automatic run_packet(input logic [18:0] addr, input int len, input int pct,
                            input int wf_lo, input int wf_hi, input int cf_lo, input int cf_hi,
                            input int swap_at, output int last_cmd);
    logic [63:0] words[$];
    logic [17:0] lo;
    logic [29:0] exp_ba;
    int total, widx, wseen, cseen, dseen, done_cyc, extra, cyc, budget;
    total = len * 8; widx = 0; wseen = 0; cseen = 0; dseen = 0;
    done_cyc = -1; extra = 0; cyc = 0; budget = 60 * len + 40; last_cmd = -1;
    for (int i = 0; i < total; i++) words.push_back({$urandom(), $urandom()});

    checks++;
    if (bus.pkt_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL pkt_ready_idle got %b want 1", bus.pkt_ready_out);
    end
    bus.pkt_start_in = 1'b1;
    bus.pkt_addr_in  = addr;
    bus.pkt_len_in   = 8'(len);
    tick();
    bus.pkt_start_in = 1'b0;
    bus.pkt_addr_in  = 19'($urandom());
    bus.pkt_len_in   = 8'($urandom());

    while (extra < 4 && cyc < budget) begin
      bus.in_valid        = (widx < total) && ($urandom_range(0, 99) >= pct);
      bus.in_data         = (widx < total) ? words[widx] : {$urandom(), $urandom()};
      bus.mcb_wr_full_in  = (cyc >= wf_lo && cyc <= wf_hi) || ($urandom_range(0, 99) < pct);
      bus.mcb_cmd_full_in = (cyc >= cf_lo && cyc <= cf_hi) || ($urandom_range(0, 99) < pct);
      bus.fb_swap_in      = (cyc == swap_at);
      @(negedge clk);

      checks++;
      if (bus.mcb_wr_en_out !== (bus.in_valid & bus.in_ready)) begin
        errors++;
        $display("FAIL wr_en_handshake cyc %0d got %b want %b", cyc, bus.mcb_wr_en_out,
                 bus.in_valid & bus.in_ready);
      end
      checks++;
      if ((bus.in_ready || bus.mcb_wr_en_out) && bus.mcb_wr_full_in) begin
        errors++;
        $display("FAIL wr_while_full cyc %0d got ready=%b wr_en=%b want 0", cyc,
                 bus.in_ready, bus.mcb_wr_en_out);
      end
      checks++;
      if (bus.mcb_cmd_en_out && bus.mcb_cmd_full_in) begin
        errors++;
        $display("FAIL cmd_while_full cyc %0d got cmd_en=1 want 0", cyc);
      end
      if (dseen == 0) begin
        checks++;
        if (bus.fb_num_out !== fb_exp) begin
          errors++;
          $display("FAIL fb_num_mid_packet cyc %0d got %b want %b", cyc, bus.fb_num_out, fb_exp);
        end
      end
      if (bus.in_valid && bus.in_ready) widx++;
      if (bus.mcb_wr_en_out) begin
        checks++;
        if (wseen >= total || bus.mcb_wr_data_out !== words[wseen]) begin
          errors++;
          $display("FAIL wr_data word %0d got %h want %h", wseen, bus.mcb_wr_data_out,
                   (wseen < total) ? words[wseen] : 64'h0);
        end
        wseen++;
      end
      if (bus.mcb_cmd_en_out) begin
        lo     = addr[17:0] + 18'(cseen);
        exp_ba = {5'b0, addr[18], lo, 6'b0};
        checks++;
        if (bus.mcb_cmd_byte_addr_out !== exp_ba || bus.mcb_cmd_bl_out !== 6'd7 ||
            bus.mcb_cmd_instr_out !== 3'b000 || bus.mcb_wr_mask_out !== 8'h00) begin
          errors++;
          $display("FAIL cmd_fields cmd %0d got addr=%h bl=%0d instr=%0d mask=%h want addr=%h bl=7 instr=0 mask=00",
                   cseen, bus.mcb_cmd_byte_addr_out, bus.mcb_cmd_bl_out,
                   bus.mcb_cmd_instr_out, bus.mcb_wr_mask_out, exp_ba);
        end
        checks++;
        if (wseen < 8 * (cseen + 1)) begin
          errors++;
          $display("FAIL data_before_cmd cmd %0d got words=%0d want >=%0d", cseen, wseen,
                   8 * (cseen + 1));
        end
        cseen++;
        last_cmd = cyc;
      end
      if (bus.done_out) begin
        dseen++;
        if (dseen == 1) done_cyc = cyc;
      end
      if (dseen > 0) extra++;
      cyc++;
      tick();
    end
    idle_inputs();

    checks++;
    if (dseen != 1) begin
      errors++;
      $display("FAIL done_count got %0d want 1 (cycles %0d)", dseen, cyc);
    end
    checks++;
    if (wseen != total || cseen != len) begin
      errors++;
      $display("FAIL totals got words=%0d cmds=%0d want words=%0d cmds=%0d", wseen, cseen,
               total, len);
    end
    checks++;
    if (done_cyc != ((len == 0) ? 0 : last_cmd + 1)) begin
      errors++;
      $display("FAIL done_timing got cyc %0d want %0d", done_cyc,
               (len == 0) ? 0 : last_cmd + 1);
    end
    if (swap_at >= 0) fb_exp = ~fb_exp;
    checks++;
    if (bus.fb_num_out !== fb_exp) begin
      errors++;
      $display("FAIL fb_num_after_packet got %b want %b", bus.fb_num_out, fb_exp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    fb_exp = 1'b0;
    tick();
  endtask

  task automatic test_single_burst();
    int lc;
    run_packet(19'h00000, 1, 0, -1, -1, -1, -1, -1, lc);
    checks++;
    if (lc != 8) begin
      errors++;
      $display("FAIL single_cmd_cycle got %0d want 8", lc);
    end
  endtask

  task automatic test_back_to_back();
    int lc;
    // fb=1, line=5, burst 0 -> first byte address 0x100A000
    run_packet({1'b1, 11'd5, 7'd0}, 80, 0, -1, -1, -1, -1, -1, lc);
    checks++;
    if (lc != 9 * 80 - 1) begin
      errors++;
      $display("FAIL b2b_last_cmd_cycle got %0d want %0d", lc, 9 * 80 - 1);
    end
  endtask

  task automatic test_line_carry();
    int lc;
    run_packet({1'b0, 11'd3, 7'h7F}, 2, 0, -1, -1, -1, -1, -1, lc);
    run_packet({1'b0, 18'h3FFFF}, 2, 0, -1, -1, -1, -1, -1, lc);
    run_packet({1'b1, 18'h3FFFF}, 2, 0, -1, -1, -1, -1, -1, lc);
  endtask

  task automatic test_backpressure();
    int lc;
    run_packet(19'h12345, 1, 0, 3, 7, 13, 15, -1, lc);
    checks++;
    if (lc != 16) begin
      errors++;
      $display("FAIL stalled_cmd_cycle got %0d want 16", lc);
    end
  endtask

  task automatic test_swap();
    int lc;
    run_packet(19'h00100, 3, 0, -1, -1, -1, -1, 5, lc);
    run_packet(19'h00200, 0, 0, -1, -1, -1, -1, -1, lc);
    bus.fb_swap_in = 1'b1;
    tick();
    bus.fb_swap_in = 1'b0;
    tick(); tick(); tick();
    fb_exp = ~fb_exp;
    checks++;
    if (bus.fb_num_out !== fb_exp) begin
      errors++;
      $display("FAIL swap_idle got %b want %b", bus.fb_num_out, fb_exp);
    end
  endtask

  task automatic test_random_packets();
    int lc, len, swap_at;
    logic [18:0] addr;
    for (int p = 0; p < 10; p++) begin
      addr = 19'($urandom());
      if ($urandom_range(0, 2) == 0) addr[17:0] = 18'h3FFFF - 18'($urandom_range(0, 3));
      len     = $urandom_range(0, 5);
      swap_at = (len > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : -1;
      run_packet(addr, len, 25, -1, -1, -1, -1, swap_at, lc);
    end
  endtask

  task automatic test_reset_mid_data();
    bus.pkt_start_in = 1'b1;
    bus.pkt_addr_in  = 19'h0ABCD;
    bus.pkt_len_in   = 8'd2;
    tick();
    bus.pkt_start_in = 1'b0;
    bus.in_valid     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = {$urandom(), $urandom()};
      tick();
    end
    checks++;
    if (bus.mcb_wr_en_out !== 1'b1) begin
      errors++;
      $display("FAIL word3_offered got wr_en=%b want 1", bus.mcb_wr_en_out);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_data");
    idle_inputs();
    tick();
    rst = 1'b0;
    fb_exp = 1'b0;
    tick();
  endtask

  task automatic test_error_sticky();
    bus.mcb_wr_underrun_in = 1'b1;
    tick();
    bus.mcb_wr_underrun_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.err_out !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky cyc %0d got %b want 1", i, bus.err_out);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.err_out !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared got %b want 0", bus.err_out);
    end
    tick();
    rst = 1'b0;
    tick();
    bus.mcb_wr_error_in = 1'b1;
    tick();
    bus.mcb_wr_error_in = 1'b0;
    tick();
    checks++;
    if (bus.err_out !== 1'b1) begin
      errors++;
      $display("FAIL err_on_wr_error got %b want 1", bus.err_out);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_line_carry();
    test_backpressure();
    test_swap();
    test_random_packets();
    test_reset_mid_data();
    test_error_sticky();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
